// File: rtl/gate_exerciser.sv
// gate_exerciser: exhaustively drives the four {a,b} vectors into an external
// 2-input gate, holds each vector for SETTLE_CYCLES cycles, samples the gate
// output for one cycle and scores it against a truth table latched at start.
//
// Handshake: start is a level request sampled only in IDLE; the pass begins on
// the edge that sees start=1 in IDLE. abort is sampled only while busy. done is
// a one-cycle pulse and the result outputs (pass, err_count, first_fail_*) stay
// stable until the next accepted start.
module gate_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] truth_table,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       first_fail_valid,
  output logic [1:0] first_fail_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Settle counter counts down to zero, so DRIVE lasts exactly SETTLE_CYCLES.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] vec;
  logic [3:0] settle_cnt;
  logic [3:0] table_q;
  logic       mismatch;
  logic [2:0] err_next;

  // Compare the gate output against the latched expectation for this vector.
  always_comb begin
    mismatch = (dut_y != table_q[vec]);
    err_next = err_count + {2'b00, mismatch};
  end

  // Sequencer: vector stepping, settle timing, scoring and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      vec              <= 2'd0;
      settle_cnt       <= 4'd0;
      table_q          <= 4'd0;
      dut_a            <= 1'b0;
      dut_b            <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= 3'd0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state            <= DRIVE;
            table_q          <= truth_table;
            vec              <= 2'd0;
            settle_cnt       <= SETTLE_LOAD;
            dut_a            <= 1'b0;
            dut_b            <= 1'b0;
            busy             <= 1'b1;
            pass             <= 1'b0;
            err_count        <= 3'd0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= 2'd0;
          end
        end
        DRIVE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
            dut_a <= 1'b0;
            dut_b <= 1'b0;
          end else if (settle_cnt == 4'd0) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            // Abort wins over this cycle's comparison.
            state <= IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
            dut_a <= 1'b0;
            dut_b <= 1'b0;
          end else begin
            if (mismatch) begin
              err_count <= err_next;
              if (!first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_vec   <= vec;
              end
            end
            if (vec == 2'd3) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 3'd0);
              dut_a <= 1'b0;
              dut_b <= 1'b0;
            end else begin
              state      <= DRIVE;
              vec        <= vec + 2'd1;
              settle_cnt <= SETTLE_LOAD;
              {dut_a, dut_b} <= vec + 2'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: a behavioural gate drives dut_y, directed and
// random passes are scored against a reference computed from the vector
// schedule (vector k is sampled in cycle (k+1)*(S+1) after the start edge).
module tb_gate_exerciser;

  localparam int S = 2;
  localparam int DONE_CYCLE = 4 * (S + 1) + 1;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] truth_table;
  logic       dut_y;
  logic       dut_a;
  logic       dut_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic       first_fail_valid;
  logic [1:0] first_fail_vec;

  // Behavioural gate under test
  logic [3:0] gate_tt;
  logic       stuck_en;
  logic       stuck_val;

  int n_cmp;
  int n_bad;
  logic [6:0] exp_q[$];

  gate_exerciser #(.SETTLE_CYCLES(S)) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .truth_table      (truth_table),
    .dut_y            (dut_y),
    .dut_a            (dut_a),
    .dut_b            (dut_b),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate model: selected by the exerciser's drive, optionally stuck.
  always_comb begin
    dut_y = stuck_en ? stuck_val : gate_tt[{dut_a, dut_b}];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: score the vectors whose sample cycle precedes the cut cycle.
  task automatic model_push(input logic [3:0] tt, input int cut, input bit was_reset);
    int         err;
    logic       ffv;
    logic [1:0] ffvec;
    logic       y;
    err = 0; ffv = 1'b0; ffvec = 2'd0;
    if (!was_reset) begin
      for (int k = 0; k < 4; k++) begin
        if ((k + 1) * (S + 1) < cut) begin
          y = stuck_en ? stuck_val : gate_tt[k];
          if (y != tt[k]) begin
            err++;
            if (!ffv) begin
              ffv = 1'b1;
              ffvec = 2'(k);
            end
          end
        end
      end
    end
    exp_q.push_back({(cut == DONE_CYCLE && err == 0 && !was_reset), 3'(err), ffv, ffvec});
  endtask

  function automatic logic [6:0] result_now();
    return {pass, err_count, first_fail_valid, first_fail_vec};
  endfunction

  // One pass: abort_at / rst_at give the cycle (1..12) of the event, 0 = none.
  task automatic run_pass(input logic [3:0] tt, input logic [3:0] gate,
                          input logic s_en, input logic s_val,
                          input int abort_at, input int rst_at,
                          input bit meddle, input bit abort_with_start);
    int         cut;
    bit         was_reset;
    bit         saw_done;
    logic [6:0] exp_res;
    logic [1:0] ev;
    gate_tt   = gate;
    stuck_en  = s_en;
    stuck_val = s_val;
    cut       = DONE_CYCLE;
    was_reset = 1'b0;
    @(negedge clk);
    truth_table = tt;
    start = 1'b1;
    abort = abort_with_start;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    for (int n = 1; n <= DONE_CYCLE; n++) begin
      @(negedge clk);
      if (n < DONE_CYCLE) begin
        ev = 2'((n - 1) / (S + 1));
        check($sformatf("busy_c%0d", n), busy, 1'b1);
        check($sformatf("vec_c%0d", n), {dut_a, dut_b}, ev);
        check($sformatf("nodone_c%0d", n), done, 1'b0);
      end else begin
        check("done_pulse", done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_vec", {dut_a, dut_b}, 2'b00);
      end
      if (meddle && n == 3) begin
        start = 1'b1;
        truth_table = ~tt;
      end
      if (meddle && n == 4) start = 1'b0;
      if (n == abort_at) begin
        abort = 1'b1;
        cut = n;
        @(posedge clk);
        #1 abort = 1'b0;
        break;
      end
      if (n == rst_at) begin
        rst_n = 1'b0;
        cut = n;
        was_reset = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        break;
      end
    end
    start = 1'b0;
    model_push(tt, cut, was_reset);
    @(negedge clk);
    exp_res = exp_q.pop_front();
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);
    check("idle_vec", {dut_a, dut_b}, 2'b00);
    check("result", result_now(), exp_res);
    // Idle hold: abort is ignored, nothing changes, no stray done.
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      abort = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    abort = 1'b0;
    check("idle_no_done", saw_done, 1'b0);
    check("idle_hold", result_now(), exp_res);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    truth_table = 4'd0;
    gate_tt = 4'd0;
    stuck_en = 1'b0;
    stuck_val = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ab", {dut_a, dut_b}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result_now(), 7'd0);

    // NAND against NAND table: clean pass
    run_pass(4'b0111, 4'b0111, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    // Output stuck high: only vector 11 fails
    run_pass(4'b0111, 4'b0000, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    // AND against NAND table: every vector fails
    run_pass(4'b0111, 4'b1000, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    // Start re-pulsed and table changed mid-pass
    run_pass(4'b0111, 4'b0111, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    run_pass(4'b0110, 4'b1110, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    // Abort during vector 2 with a failing gate (in DRIVE, then in SAMPLE)
    run_pass(4'b0111, 4'b1000, 1'b0, 1'b0, 2 * (S + 1) + 2, 0, 1'b0, 1'b0);
    run_pass(4'b0111, 4'b1000, 1'b0, 1'b0, 3 * (S + 1), 0, 1'b0, 1'b0);
    // Reset during DRIVE of vector 1, then a clean pass
    run_pass(4'b0111, 4'b1000, 1'b0, 1'b0, 0, S + 2, 1'b0, 1'b0);
    check("post_rst_result", result_now(), 7'd0);
    run_pass(4'b0111, 4'b0111, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    // Abort together with start in IDLE: start wins
    run_pass(4'b1001, 4'b1011, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);

    // Random passes
    for (int r = 0; r < 12; r++) begin
      run_pass(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, DONE_CYCLE - 1)) : 0,
               0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
